cv32e40p_ex_wb_pipeline: RTL and testbench



---
 rtl/cv32e40p_ex_wb_pipeline.sv | 156 +++++++++++++++
 tb/tb_cv32e40p_ex_wb_pipeline.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_ex_wb_pipeline.sv
// cv32e40p_ex_wb_pipeline
//   EX->WB load-writeback stage. Tracks one granted LSU access from EX until
//   its final response returns, then issues a single-cycle regfile write for
//   loads. Stores and no-writeback loads retire silently. Responses that
//   arrive while idle, and accesses that never get a response, are flagged.
//
//   Optional feature macro: FT_WB_PARITY_EN adds an even-parity bit over the
//   latched {we, waddr, sel_mux} and the parity_err_o output.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   ex_valid_i / wb_ready_o  EX handover handshake (accept = valid & ready)
//   data_we_ex_i             1 = store, 0 = load
//   split_ex_i               misaligned access, two responses expected
//   regfile_we_ex_i          load writes the regfile
//   regfile_waddr_ex_i       load destination register
//   sel_mux_ex_i             redundancy select carried through to WB
//   lsu_rvalid_i, lsu_rdata_i LSU response (data valid on final response)
//   regfile_*_wb_o           regfile write port (strobe plus held address/data)
//   sel_mux_wb_o             sel_mux of the written instruction
//   spurious_rsp_o           pulse: response arrived while idle
//   parity_err_o             pulse: latched control failed parity (macro only)
//   timeout_o                pulse: TIMEOUT_CYCLES without a response
module cv32e40p_ex_wb_pipeline #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  output logic        wb_ready_o,
  input  logic        data_we_ex_i,
  input  logic        split_ex_i,
  input  logic        regfile_we_ex_i,
  input  logic [5:0]  regfile_waddr_ex_i,
  input  logic [2:0]  sel_mux_ex_i,
  input  logic        lsu_rvalid_i,
  input  logic [31:0] lsu_rdata_i,
  output logic        regfile_we_wb_o,
  output logic [5:0]  regfile_waddr_wb_o,
  output logic [31:0] regfile_wdata_wb_o,
  output logic [2:0]  sel_mux_wb_o,
  output logic        spurious_rsp_o,
`ifdef FT_WB_PARITY_EN
  output logic        parity_err_o,
`endif
  output logic        timeout_o
);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [1:0]       rsp_left;
  logic [CNT_W-1:0] tmo_cnt;

  // Tracking registers for the in-flight access; kept apart from the write
  // port registers so a same-cycle reload cannot disturb a pending write.
  logic       lat_we;
  logic       lat_store;
  logic [5:0] lat_waddr;
  logic [2:0] lat_sel;

  logic final_rsp;
  logic accept;
  logic perr;

  assign final_rsp  = (state == WAIT_RSP) && lsu_rvalid_i && (rsp_left == 2'd1);
  assign wb_ready_o = (state == IDLE) || final_rsp;
  assign accept     = ex_valid_i && wb_ready_o;

`ifdef FT_WB_PARITY_EN
  logic lat_par;
  assign perr = (state == WAIT_RSP) && ((^{lat_we, lat_waddr, lat_sel}) != lat_par);
`else
  assign perr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      rsp_left           <= 2'd0;
      tmo_cnt            <= '0;
      lat_we             <= 1'b0;
      lat_store          <= 1'b0;
      lat_waddr          <= 6'd0;
      lat_sel            <= 3'd0;
      regfile_we_wb_o    <= 1'b0;
      regfile_waddr_wb_o <= 6'd0;
      regfile_wdata_wb_o <= 32'd0;
      sel_mux_wb_o       <= 3'd0;
      spurious_rsp_o     <= 1'b0;
      timeout_o          <= 1'b0;
`ifdef FT_WB_PARITY_EN
      lat_par            <= 1'b0;
      parity_err_o       <= 1'b0;
`endif
    end else begin
      regfile_we_wb_o <= 1'b0;
      spurious_rsp_o  <= 1'b0;
      timeout_o       <= 1'b0;
`ifdef FT_WB_PARITY_EN
      parity_err_o    <= 1'b0;
`endif

      // Response with nothing outstanding: report it and drop the data.
      if ((state == IDLE) && lsu_rvalid_i)
        spurious_rsp_o <= 1'b1;

      if (state == WAIT_RSP) begin
        if (perr) begin
          // Corrupted control: abandon the access without writing.
          state <= IDLE;
`ifdef FT_WB_PARITY_EN
          parity_err_o <= 1'b1;
`endif
        end else if (lsu_rvalid_i) begin
          if (rsp_left == 2'd2) begin
            // First half of a misaligned access; data is merged by the LSU.
            rsp_left <= 2'd1;
            tmo_cnt  <= '0;
          end else begin
            state <= IDLE;
            if (lat_we && !lat_store) begin
              regfile_we_wb_o    <= 1'b1;
              regfile_waddr_wb_o <= lat_waddr;
              regfile_wdata_wb_o <= lsu_rdata_i;
              sel_mux_wb_o       <= lat_sel;
            end
          end
        end else if (tmo_cnt == TMO_LAST) begin
          timeout_o <= 1'b1;
          state     <= IDLE;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end

      // Accept last so a back-to-back handover overrides the return to IDLE.
      if (accept) begin
        state     <= WAIT_RSP;
        rsp_left  <= split_ex_i ? 2'd2 : 2'd1;
        tmo_cnt   <= '0;
        lat_we    <= regfile_we_ex_i;
        lat_store <= data_we_ex_i;
        lat_waddr <= regfile_waddr_ex_i;
        lat_sel   <= sel_mux_ex_i;
`ifdef FT_WB_PARITY_EN
        lat_par   <= ^{regfile_we_ex_i, regfile_waddr_ex_i, sel_mux_ex_i};
`endif
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_ex_wb_pipeline.sv
module tb_cv32e40p_ex_wb_pipeline;
  localparam int TMO = 64;

  typedef struct packed {
    logic       store;
    logic       split;
    logic       we;
    logic [5:0] waddr;
    logic [2:0] sel;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, wb_ready_o, data_we_ex_i, split_ex_i, regfile_we_ex_i;
  logic [5:0]  regfile_waddr_ex_i;
  logic [2:0]  sel_mux_ex_i;
  logic        lsu_rvalid_i;
  logic [31:0] lsu_rdata_i;
  logic        regfile_we_wb_o;
  logic [5:0]  regfile_waddr_wb_o;
  logic [31:0] regfile_wdata_wb_o;
  logic [2:0]  sel_mux_wb_o;
  logic        spurious_rsp_o, timeout_o;
`ifdef FT_WB_PARITY_EN
  logic        parity_err_o;
`endif

  logic [41:0] wb_t;
  assign wb_t = {regfile_we_wb_o, regfile_waddr_wb_o, regfile_wdata_wb_o, sel_mux_wb_o};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cv32e40p_ex_wb_pipeline #(.TIMEOUT_CYCLES(TMO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .wb_ready_o(wb_ready_o),
    .data_we_ex_i(data_we_ex_i), .split_ex_i(split_ex_i),
    .regfile_we_ex_i(regfile_we_ex_i), .regfile_waddr_ex_i(regfile_waddr_ex_i),
    .sel_mux_ex_i(sel_mux_ex_i),
    .lsu_rvalid_i(lsu_rvalid_i), .lsu_rdata_i(lsu_rdata_i),
    .regfile_we_wb_o(regfile_we_wb_o), .regfile_waddr_wb_o(regfile_waddr_wb_o),
    .regfile_wdata_wb_o(regfile_wdata_wb_o), .sel_mux_wb_o(sel_mux_wb_o),
    .spurious_rsp_o(spurious_rsp_o),
`ifdef FT_WB_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .timeout_o(timeout_o)
  );

  function automatic acc_t gen();
    acc_t a;
    a.store = ($urandom_range(0, 3) == 0);
    a.split = ($urandom_range(0, 2) == 0);
    a.we    = ($urandom_range(0, 3) != 0);
    a.waddr = 6'($urandom);
    a.sel   = 3'($urandom);
    return a;
  endfunction

  task automatic drive(input acc_t a);
    data_we_ex_i       = a.store;
    split_ex_i         = a.split;
    regfile_we_ex_i    = a.we;
    regfile_waddr_ex_i = a.waddr;
    sel_mux_ex_i       = a.sel;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_t !== 42'd0 || spurious_rsp_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got wb=%h sp=%b to=%b exp all 0", wb_t, spurious_rsp_o, timeout_o);
    end
    checks++;
    if (wb_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", wb_ready_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_basic();
    drive('{store:1'b0, split:1'b0, we:1'b1, waddr:6'd5, sel:3'd5});
    ex_valid_i = 1'b1;
    #1 checks++;
    if (wb_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready_idle: got %b exp 1", wb_ready_o); end
    @(negedge clk); ex_valid_i = 1'b0;
    #1 checks++;
    if (wb_ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready_wait: got %b exp 0", wb_ready_o); end
    @(negedge clk);
    @(negedge clk); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hDEADBEEF;
    #1 checks++;
    if (wb_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready_final: got %b exp 1", wb_ready_o); end
    @(negedge clk); lsu_rvalid_i = 1'b0;
    checks++;
    if (wb_t !== {1'b1, 6'd5, 32'hDEADBEEF, 3'd5}) begin
      errors++; $display("FAIL basic_write: got %h exp %h", wb_t, {1'b1, 6'd5, 32'hDEADBEEF, 3'd5});
    end
    @(negedge clk);
    checks++;
    if (wb_t !== {1'b0, 6'd5, 32'hDEADBEEF, 3'd5}) begin
      errors++; $display("FAIL basic_hold: got %h exp %h", wb_t, {1'b0, 6'd5, 32'hDEADBEEF, 3'd5});
    end
  endtask

  task automatic test_misaligned();
    drive('{store:1'b0, split:1'b1, we:1'b1, waddr:6'd7, sel:3'd2});
    ex_valid_i = 1'b1;
    @(negedge clk); ex_valid_i = 1'b0; lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h11;
    #1 checks++;
    if (wb_ready_o !== 1'b0) begin errors++; $display("FAIL mis_ready_first: got %b exp 0", wb_ready_o); end
    @(negedge clk); lsu_rvalid_i = 1'b0;
    checks++;
    if (regfile_we_wb_o !== 1'b0) begin errors++; $display("FAIL mis_no_early_write: got %b exp 0", regfile_we_wb_o); end
    @(negedge clk); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hAABBCCDD;
    @(negedge clk); lsu_rvalid_i = 1'b0;
    checks++;
    if (wb_t !== {1'b1, 6'd7, 32'hAABBCCDD, 3'd2}) begin
      errors++; $display("FAIL mis_write: got %h exp %h", wb_t, {1'b1, 6'd7, 32'hAABBCCDD, 3'd2});
    end
    @(negedge clk);
    checks++;
    if (regfile_we_wb_o !== 1'b0) begin errors++; $display("FAIL mis_single_strobe: got %b exp 0", regfile_we_wb_o); end
  endtask

  task automatic test_back_to_back();
    drive('{store:1'b0, split:1'b0, we:1'b1, waddr:6'd1, sel:3'd1});
    ex_valid_i = 1'b1;
    @(negedge clk); ex_valid_i = 1'b0;
    @(negedge clk); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h11110001;
    drive('{store:1'b0, split:1'b0, we:1'b1, waddr:6'd2, sel:3'd6});
    ex_valid_i = 1'b1;
    #1 checks++;
    if (wb_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", wb_ready_o); end
    @(negedge clk); lsu_rvalid_i = 1'b0; ex_valid_i = 1'b0;
    checks++;
    if (wb_t !== {1'b1, 6'd1, 32'h11110001, 3'd1}) begin
      errors++; $display("FAIL b2b_write_x1: got %h exp %h", wb_t, {1'b1, 6'd1, 32'h11110001, 3'd1});
    end
    #1 checks++;
    if (wb_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_x2_tracked: got %b exp 0", wb_ready_o); end
    @(negedge clk); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h22220002;
    @(negedge clk); lsu_rvalid_i = 1'b0;
    checks++;
    if (wb_t !== {1'b1, 6'd2, 32'h22220002, 3'd6}) begin
      errors++; $display("FAIL b2b_write_x2: got %h exp %h", wb_t, {1'b1, 6'd2, 32'h22220002, 3'd6});
    end
    @(negedge clk);
  endtask

  task automatic test_store_spurious();
    drive('{store:1'b1, split:1'b0, we:1'b1, waddr:6'd9, sel:3'd3});
    ex_valid_i = 1'b1;
    @(negedge clk); ex_valid_i = 1'b0; lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hCAFEF00D;
    @(negedge clk); lsu_rvalid_i = 1'b0;
    checks++;
    if (wb_t !== {1'b0, 6'd2, 32'h22220002, 3'd6} || spurious_rsp_o !== 1'b0) begin
      errors++; $display("FAIL store_no_write: got wb=%h sp=%b exp wb=%h sp=0", wb_t, spurious_rsp_o,
                         {1'b0, 6'd2, 32'h22220002, 3'd6});
    end
    @(negedge clk); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h0BADBAD0;
    @(negedge clk); lsu_rvalid_i = 1'b0;
    checks++;
    if (spurious_rsp_o !== 1'b1 || regfile_we_wb_o !== 1'b0) begin
      errors++; $display("FAIL spurious_pulse: got sp=%b we=%b exp sp=1 we=0", spurious_rsp_o, regfile_we_wb_o);
    end
    @(negedge clk);
    checks++;
    if (spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL spurious_one_cycle: got %b exp 0", spurious_rsp_o); end
  endtask

  task automatic test_timeout();
    int bad = 0;
    drive('{store:1'b0, split:1'b0, we:1'b1, waddr:6'd12, sel:3'd4});
    ex_valid_i = 1'b1;
    @(negedge clk); ex_valid_i = 1'b0;
    for (int k = 1; k < TMO; k++) begin
      @(negedge clk);
      if (timeout_o !== 1'b0 || wb_ready_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL timeout_early: got %0d bad cycles exp 0", bad); end
    @(negedge clk);
    checks++;
    if (timeout_o !== 1'b1 || wb_ready_o !== 1'b1 || regfile_we_wb_o !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: got to=%b rdy=%b we=%b exp 1 1 0", timeout_o, wb_ready_o, regfile_we_wb_o);
    end
    @(negedge clk);
    checks++;
    if (timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle: got %b exp 0", timeout_o); end
  endtask

  task automatic test_reset_mid();
    drive('{store:1'b0, split:1'b0, we:1'b1, waddr:6'd3, sel:3'd7});
    ex_valid_i = 1'b1;
    @(negedge clk); ex_valid_i = 1'b0;
    #2 rst = 1'b1;
    #1 checks++;
    if (wb_ready_o !== 1'b1 || wb_t !== 42'd0) begin
      errors++; $display("FAIL rst_mid_async: got rdy=%b wb=%h exp rdy=1 wb=0", wb_ready_o, wb_t);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h12345678;
    @(negedge clk); lsu_rvalid_i = 1'b0;
    checks++;
    if (spurious_rsp_o !== 1'b1 || regfile_we_wb_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_spurious: got sp=%b we=%b exp sp=1 we=0", spurious_rsp_o, regfile_we_wb_o);
    end
    @(negedge clk);
  endtask

  // Transaction-level model: each access gets its responses after random
  // gaps; loads with we produce exactly one write the cycle after the final
  // response, everything else leaves the write port holding its last values.
  task automatic test_random();
    acc_t        cur, nxt;
    logic        b2b = 1'b0;
    logic [31:0] d = 32'd0;
    logic [5:0]  la = 6'd0;
    logic [31:0] ld = 32'd0;
    logic [2:0]  ls = 3'd0;
    int          nr, gap;
    cur = gen();
    for (int i = 0; i < 40; i++) begin
      if (!b2b) begin
        drive(cur); ex_valid_i = 1'b1;
        #1 checks++;
        if (wb_ready_o !== 1'b1) begin errors++; $display("FAIL rnd_ready_idle[%0d]: got %b exp 1", i, wb_ready_o); end
        @(negedge clk); ex_valid_i = 1'b0;
      end
      nr = cur.split ? 2 : 1;
      for (int r = 0; r < nr; r++) begin
        gap = int'($urandom_range(0, 3));
        repeat (gap) begin
          lsu_rvalid_i = 1'b0;
          #1 checks++;
          if (wb_ready_o !== 1'b0) begin errors++; $display("FAIL rnd_ready_wait[%0d]: got %b exp 0", i, wb_ready_o); end
          @(negedge clk);
          checks++;
          if (regfile_we_wb_o !== 1'b0) begin errors++; $display("FAIL rnd_gap_strobe[%0d]: got %b exp 0", i, regfile_we_wb_o); end
        end
        lsu_rvalid_i = 1'b1; d = $urandom; lsu_rdata_i = d;
        #1 checks++;
        if (wb_ready_o !== ((r == nr - 1) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL rnd_ready_rsp[%0d.%0d]: got %b exp %b", i, r, wb_ready_o, (r == nr - 1));
        end
        if (r < nr - 1) begin
          @(negedge clk); lsu_rvalid_i = 1'b0;
          checks++;
          if (regfile_we_wb_o !== 1'b0) begin errors++; $display("FAIL rnd_first_strobe[%0d]: got %b exp 0", i, regfile_we_wb_o); end
        end
      end
      b2b = (i < 39) && ($urandom_range(0, 1) == 1);
      if (b2b) begin nxt = gen(); drive(nxt); ex_valid_i = 1'b1; end
      @(negedge clk); lsu_rvalid_i = 1'b0; ex_valid_i = 1'b0;
      checks++;
      if (!cur.store && cur.we) begin
        la = cur.waddr; ld = d; ls = cur.sel;
        if (wb_t !== {1'b1, la, ld, ls}) begin
          errors++; $display("FAIL rnd_write[%0d]: got %h exp %h", i, wb_t, {1'b1, la, ld, ls});
        end
      end else if (wb_t !== {1'b0, la, ld, ls}) begin
        errors++; $display("FAIL rnd_hold[%0d]: got %h exp %h", i, wb_t, {1'b0, la, ld, ls});
      end
      if (b2b) cur = nxt;
      else begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          checks++;
          if (regfile_we_wb_o !== 1'b0) begin errors++; $display("FAIL rnd_idle_strobe[%0d]: got %b exp 0", i, regfile_we_wb_o); end
        end
        cur = gen();
      end
    end
    @(negedge clk);
    checks++;
    if (regfile_we_wb_o !== 1'b0) begin errors++; $display("FAIL rnd_tail_strobe: got %b exp 0", regfile_we_wb_o); end
  endtask

`ifdef FT_WB_PARITY_EN
  task automatic test_parity();
    drive('{store:1'b0, split:1'b0, we:1'b1, waddr:6'd4, sel:3'd1});
    ex_valid_i = 1'b1;
    @(negedge clk); ex_valid_i = 1'b0;
    force dut.lat_waddr = 6'd5;
    @(negedge clk);
    checks++;
    if (parity_err_o !== 1'b1 || regfile_we_wb_o !== 1'b0 || wb_ready_o !== 1'b1) begin
      errors++; $display("FAIL parity_err: got pe=%b we=%b rdy=%b exp 1 0 1", parity_err_o, regfile_we_wb_o, wb_ready_o);
    end
    release dut.lat_waddr;
    @(negedge clk);
    checks++;
    if (parity_err_o !== 1'b0) begin errors++; $display("FAIL parity_one_cycle: got %b exp 0", parity_err_o); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ex_valid_i = 1'b0; data_we_ex_i = 1'b0; split_ex_i = 1'b0;
    regfile_we_ex_i = 1'b0; regfile_waddr_ex_i = 6'd0; sel_mux_ex_i = 3'd0;
    lsu_rvalid_i = 1'b0; lsu_rdata_i = 32'd0;
    test_reset();
    test_load_basic();
    test_misaligned();
    test_back_to_back();
    test_store_spurious();
    test_timeout();
    test_reset_mid();
    test_random();
`ifdef FT_WB_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
